tlb_op_ctrl: RTL

//  Sequences TLB-management instructions (tlbp/tlbr/tlbwi) between the EXE stage, the TLB and CP0.
//  - Accepts one op at a time.
//  - Snapshots the CP0 Index/EntryHi/EntryLo0/EntryLo1 values, then drives the TLB search/read/write ports.
//  - Returns results to CP0 write strobes.
//  - Requests a pipeline refetch after any op that can change the live translation.

---
 rtl/tlb_op_ctrl_if.sv | 58 +++++
 rtl/tlb_op_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl_if.sv
// Bus bundle between the TLB-op sequencer and its EXE/TLB/CP0/IF neighbours.
// master = the sequencer (tlb_op_ctrl); slave = the surrounding pipeline and TLB.
interface tlb_op_ctrl_if #(
    parameter int unsigned IDXW = 4
);
    logic            op_valid;
    logic [1:0]      op_type;
    logic [31:0]     op_pc;
    logic            op_ready;
    logic            ex_flush;
    logic [31:0]     cp0_index;
    logic [31:0]     cp0_hi;
    logic [31:0]     cp0_lo0;
    logic [31:0]     cp0_lo1;
    logic [18:0]     s1_vpn2;
    logic [7:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic [IDXW-1:0] r_index;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo0;
    logic [31:0]     r_lo1;
    logic            we;
    logic [IDXW-1:0] w_index;
    logic [31:0]     w_hi;
    logic [31:0]     w_lo0;
    logic [31:0]     w_lo1;
    logic            cp0_idx_we;
    logic [31:0]     cp0_idx_wd;
    logic            cp0_ent_we;
    logic [31:0]     cp0_ent_hi;
    logic [31:0]     cp0_ent_lo0;
    logic [31:0]     cp0_ent_lo1;
    logic            refetch;
    logic [31:0]     refetch_pc;
    logic            refetch_ack;
    logic            busy;

    modport master (
        input  op_valid, op_type, op_pc, ex_flush,
        input  cp0_index, cp0_hi, cp0_lo0, cp0_lo1,
        input  s1_found, s1_index, r_hi, r_lo0, r_lo1, refetch_ack,
        output op_ready, s1_vpn2, s1_asid, r_index,
        output we, w_index, w_hi, w_lo0, w_lo1,
        output cp0_idx_we, cp0_idx_wd, cp0_ent_we, cp0_ent_hi, cp0_ent_lo0, cp0_ent_lo1,
        output refetch, refetch_pc, busy
    );

    modport slave (
        output op_valid, op_type, op_pc, ex_flush,
        output cp0_index, cp0_hi, cp0_lo0, cp0_lo1,
        output s1_found, s1_index, r_hi, r_lo0, r_lo1, refetch_ack,
        input  op_ready, s1_vpn2, s1_asid, r_index,
        input  we, w_index, w_hi, w_lo0, w_lo1,
        input  cp0_idx_we, cp0_idx_wd, cp0_ent_we, cp0_ent_hi, cp0_ent_lo0, cp0_ent_lo1,
        input  refetch, refetch_pc, busy
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences tlbp/tlbr/tlbwi between EXE, the TLB and CP0, then requests a refetch.
// Define TLB_RANDOM_EN to turn op_type 00 into tlbwr driven by a free-running index counter.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
    input logic           clk,
    input logic           resetn,
    tlb_op_ctrl_if.master bus
);
    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpTlbp  = 2'b01;
    localparam logic [1:0] OpTlbr  = 2'b10;
    localparam logic [1:0] OpTlbwi = 2'b11;

    typedef enum logic [1:0] {StIdle, StLookup, StCommit, StRefetch} state_e;

    state_e          state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo0_q, lo0_d;
    logic [31:0]     lo1_q, lo1_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            accept;
    logic            unused_idx_hi;

    // Index bits above the TLB size carry no meaning.
    assign unused_idx_hi = ^bus.cp0_index[31:IDXW];

    assign accept = resetn & (state_q == StIdle) & bus.op_valid & ~bus.ex_flush;

`ifdef TLB_RANDOM_EN
    logic [IDXW-1:0] rnd_q, rnd_d;

    always_comb begin
        rnd_d = (rnd_q == '0) ? IDXW'(TLBNUM - 1) : rnd_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rnd_q <= IDXW'(TLBNUM - 1);
        end else begin
            rnd_q <= rnd_d;
        end
    end
`endif

    always_comb begin
        type_d = type_q;
        pc_d   = pc_q;
        hi_d   = hi_q;
        lo0_d  = lo0_q;
        lo1_d  = lo1_q;
        idx_d  = idx_q;
        if (accept) begin
            type_d = bus.op_type;
            pc_d   = bus.op_pc;
            hi_d   = bus.cp0_hi;
            lo0_d  = bus.cp0_lo0;
            lo1_d  = bus.cp0_lo1;
            idx_d  = bus.cp0_index[IDXW-1:0];
`ifdef TLB_RANDOM_EN
            if (bus.op_type == OpNone) begin
                idx_d = rnd_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            type_q <= '0;
            pc_q   <= '0;
            hi_q   <= '0;
            lo0_q  <= '0;
            lo1_q  <= '0;
            idx_q  <= '0;
        end else begin
            type_q <= type_d;
            pc_q   <= pc_d;
            hi_q   <= hi_d;
            lo0_q  <= lo0_d;
            lo1_q  <= lo1_d;
            idx_q  <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.op_type)
                        OpTlbp, OpTlbr: state_d = StLookup;
                        OpTlbwi:        state_d = StCommit;
`ifdef TLB_RANDOM_EN
                        default:        state_d = StCommit;
`else
                        default:        state_d = StIdle;
`endif
                    endcase
                end
            end
            StLookup:  state_d = bus.ex_flush ? StIdle : StCommit;
            // Once in COMMIT the op is architecturally complete; flush no longer matters.
            StCommit:  state_d = (type_q == OpTlbp) ? StIdle : StRefetch;
            StRefetch: state_d = bus.refetch_ack ? StIdle : StRefetch;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.op_ready    = accept;
        bus.busy        = (state_q != StIdle);
        bus.s1_vpn2     = '0;
        bus.s1_asid     = '0;
        bus.r_index     = '0;
        bus.we          = 1'b0;
        bus.w_index     = '0;
        bus.w_hi        = '0;
        bus.w_lo0       = '0;
        bus.w_lo1       = '0;
        bus.cp0_idx_we  = 1'b0;
        bus.cp0_idx_wd  = '0;
        bus.cp0_ent_we  = 1'b0;
        bus.cp0_ent_hi  = '0;
        bus.cp0_ent_lo0 = '0;
        bus.cp0_ent_lo1 = '0;
        bus.refetch     = 1'b0;
        bus.refetch_pc  = '0;
        unique case (state_q)
            StLookup: begin
                if (type_q == OpTlbp) begin
                    bus.s1_vpn2 = hi_q[31:13];
                    bus.s1_asid = hi_q[7:0];
                end else begin
                    bus.r_index = idx_q;
                end
            end
            StCommit: begin
                case (type_q)
                    OpTlbp: begin
                        bus.cp0_idx_we = 1'b1;
                        if (bus.s1_found) begin
                            bus.cp0_idx_wd[IDXW-1:0] = bus.s1_index;
                        end else begin
                            bus.cp0_idx_wd[31] = 1'b1;
                        end
                    end
                    OpTlbr: begin
                        bus.cp0_ent_we  = 1'b1;
                        bus.cp0_ent_hi  = bus.r_hi;
                        bus.cp0_ent_lo0 = bus.r_lo0;
                        bus.cp0_ent_lo1 = bus.r_lo1;
                    end
                    default: begin
                        bus.we      = 1'b1;
                        bus.w_index = idx_q;
                        bus.w_hi    = hi_q;
                        bus.w_lo0   = lo0_q;
                        bus.w_lo1   = lo1_q;
                    end
                endcase
            end
            StRefetch: begin
                bus.refetch    = 1'b1;
                bus.refetch_pc = pc_q + 32'd4;
            end
            default: ;
        endcase
    end
endmodule
